// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared frame-buffer geometry, colours and renderer state encoding
package gfx_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOUR_BG     = 3'b000;
  localparam logic [2:0] COLOUR_BULLET = 3'b110;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_REQ,
    RS_ERASE,
    RS_DRAW,
    RS_FIN
  } render_state_e;

endpackage

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - row-major (dx fastest) offset counter over a W x H rectangle
module rect_scanner #(
  parameter int W = 2,
  parameter int H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);

  logic [2:0] dx_q, dy_q;
  logic       row_end;

  assign row_end = (dx_q == 3'(W - 1));
  assign last    = row_end && (dy_q == 3'(H - 1));
  assign dx      = dx_q;
  assign dy      = dy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (clear) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (step) begin
      if (row_end) begin
        dx_q <= '0;
        dy_q <= last ? 3'd0 : dy_q + 3'd1;
      end else begin
        dx_q <= dx_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/bullet_renderer.sv
// rtl/bullet_renderer.sv - erases last frame's bullet and draws the new one, one pixel per granted cycle
module bullet_renderer
  import gfx_pkg::*;
#(
  parameter int         SPRITE_W      = 2,
  parameter int         SPRITE_H      = 4,
  parameter logic [2:0] BULLET_COLOUR = COLOUR_BULLET,
  parameter logic [2:0] BG_COLOUR     = COLOUR_BG
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic       bullet_active,
  input  logic       gnt,
  output logic       req,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  render_state_e state_q, state_d, first_phase, cur_phase;

  logic [7:0] new_x_q, old_x_q, base_x;
  logic [6:0] new_y_q, old_y_q, base_y;
  logic       new_act_q, have_old_q;
  logic       req_q, busy_q, done_q, plot_q, overrun_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_colour_q;

  logic [2:0] dx, dy;
  logic       last, scan_clear, scan_step;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       in_bounds, issue, tick_ok;

  rect_scanner #(.W(SPRITE_W), .H(SPRITE_H)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (scan_clear),
    .step   (scan_step),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  // The granted REQ cycle already issues the first pixel of the first rectangle,
  // so the registered pixel appears in the cycle after the grant.
  always_comb begin
    first_phase = have_old_q ? RS_ERASE : (new_act_q ? RS_DRAW : RS_FIN);
    cur_phase   = (state_q == RS_REQ) ? first_phase : state_q;
    base_x      = (cur_phase == RS_ERASE) ? old_x_q : new_x_q;
    base_y      = (cur_phase == RS_ERASE) ? old_y_q : new_y_q;
    pix_x       = {1'b0, base_x} + {6'd0, dx};
    pix_y       = {1'b0, base_y} + {5'd0, dy};
    in_bounds   = (pix_x < 9'(SCREEN_W)) && (pix_y < 8'(SCREEN_H));
    issue       = gnt && ((cur_phase == RS_ERASE) || (cur_phase == RS_DRAW));
    tick_ok     = frame_tick && (state_q == RS_IDLE) && !done_q;
  end

  always_comb begin
    state_d    = state_q;
    scan_clear = 1'b0;
    scan_step  = 1'b0;
    case (state_q)
      RS_IDLE: begin
        if (tick_ok) begin
          state_d    = RS_REQ;
          scan_clear = 1'b1;
        end
      end
      RS_REQ, RS_ERASE, RS_DRAW: begin
        if (gnt) begin
          if (cur_phase == RS_FIN) begin
            state_d = RS_FIN;
          end else if (last) begin
            scan_clear = 1'b1;
            state_d    = ((cur_phase == RS_ERASE) && new_act_q) ? RS_DRAW : RS_FIN;
          end else begin
            scan_step = 1'b1;
            state_d   = cur_phase;
          end
        end
      end
      RS_FIN:  state_d = RS_IDLE;
      default: state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RS_IDLE;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_act_q    <= 1'b0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      have_old_q   <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      overrun_q    <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= (state_d != RS_IDLE);
      busy_q    <= (state_d != RS_IDLE);
      done_q    <= (state_q == RS_FIN);
      plot_q    <= issue && in_bounds;
      overrun_q <= overrun_q || (frame_tick && !tick_ok);
      if (tick_ok) begin
        new_x_q   <= bullet_x;
        new_y_q   <= bullet_y;
        new_act_q <= bullet_active;
      end
      if (state_q == RS_FIN) begin
        old_x_q    <= new_x_q;
        old_y_q    <= new_y_q;
        have_old_q <= new_act_q;
      end
      if (issue) begin
        vga_x_q      <= pix_x[7:0];
        vga_y_q      <= pix_y[6:0];
        vga_colour_q <= (cur_phase == RS_ERASE) ? BG_COLOUR : BULLET_COLOUR;
      end
    end
  end

  assign req        = req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign overrun    = overrun_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule

// File: doc/bullet_renderer.md
# bullet_renderer

Draws the player bullet on the 160x120 frame buffer each frame. Consumes the bullet datapath's position/active outputs, erases the rectangle drawn last frame, then draws the rectangle at the new position. It drives the shared VGA adapter port through a req/gnt arbiter, one pixel per granted cycle.

## Interface
- SPRITE_W, 2: bullet width in pixels (1..8)
- SPRITE_H, 4: bullet height in pixels (1..8)
- BULLET_COLOUR, 3'b110: draw colour
- BG_COLOUR, 3'b000: erase colour
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse: start a render pass
- bullet_x  in  8  bullet left column (datapath bulletX)
- bullet_y  in  7  bullet top row (datapath bulletY)
- bullet_active  in  1  bullet visible (datapath active)
- gnt  in  1  arbiter grant for the VGA port
- req  out  1  VGA port request
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe, one pixel per cycle
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse: pass complete
- overrun  out  1  sticky: frame_tick arrived while busy

## Operation
- States: IDLE, REQ, ERASE, DRAW, FIN.
- IDLE: on frame_tick, latch new_x/new_y/new_act from inputs; go to REQ, set busy, req.
- REQ: wait for gnt; then ERASE if have_old, else DRAW if new_act, else FIN.
- ERASE: scan old rectangle row-major (dx fastest) at old_x/old_y, colour BG_COLOUR. After last pixel: DRAW if new_act, else FIN.
- DRAW: scan new rectangle at new_x/new_y, colour BULLET_COLOUR. After last pixel, go to FIN.
- FIN: done=1 for one cycle. Drop req and busy. Copy new_x/new_y into old_x/old_y. have_old <= new_act. Return to IDLE.
- Pixel address: x = base_x + dx (9-bit sum), y = base_y + dy (8-bit sum).
- Clipping: if x >= 160 or y >= 120, the scan position still advances but vga_plot=0. No wrap onto the opposite edge.
- gnt low during ERASE/DRAW: vga_plot=0, scan counters hold, req stays 1. Resume at the same pixel when gnt returns.
- frame_tick while busy: ignored, overrun <= 1. Only reset clears overrun.
- Inputs change mid-pass: no effect; only the latched values are used.
- Reset (any state): all outputs and have_old go to 0, FSM goes to IDLE. No erase of stale pixels after reset (the screen clear is owned elsewhere).

## Timing
- Reset values: req, vga_plot, busy, done, overrun, vga_x, vga_y, vga_colour = 0.
- All outputs are registered. vga_x/vga_y/vga_colour are valid in any cycle with vga_plot=1.
- Pass with gnt held high, tick at cycle 0:
  - REQ at cycle 1.
  - First pixel at cycle 2.
  - W*H erase pixels, then W*H draw pixels, back to back.
  - done in the cycle after the last pixel.
  - Defaults: 1+1+8+8 = done at cycle 18.
- Each cycle with gnt low inside ERASE/DRAW adds exactly one cycle to the pass.
- An ERASE->DRAW transition inserts no bubble.
- done and the next accepted frame_tick may not coincide. A tick in the done cycle sets overrun.

## Structure
- Shared package gfx_pkg:
  - SCREEN_W=160, SCREEN_H=120
  - colour constants
  - render-state enum, reused by the player and enemy renderers
- Sub-module rect_scanner (params W, H):
  - inputs clk, resetn, clear, step
  - outputs dx[2:0], dy[2:0], last
  - dx wraps to 0 and dy increments at dx=W-1
  - last=1 when dx=W-1 and dy=H-1
  - clear is asserted on entry to ERASE and to DRAW

## Test plan
- First pass, gnt=1, x=80, y=99, active=1: no erase. 8 plots at (80..81, 99..102) colour 110, in row-major order. done at cycle 10.
- Second pass, new y=93: 8 BG plots at y 99..102, then 8 draw plots at y 93..96. done at cycle 18.
- Clipping, x=159, y=118: plots only at (159,118) and (159,119). Scan still takes 8 cycles.
- gnt pulled low for 3 cycles mid-DRAW: no plots while gnt is low, no pixel skipped or repeated, done delayed exactly 3 cycles.
- bullet_active=0 after a drawn pass: erase only, done at cycle 10, next pass skips erase. A tick while busy sets overrun and the pass is not restarted.
- resetn asserted mid-ERASE: vga_plot and req drop immediately (asynchronously). Next pass performs no erase.
